// File: rtl/udp_mii_frame_tx.sv
// MII (nibble-wide) transmitter for one Ethernet/IPv4/UDP frame per start request.
// Covers preamble, header with per-frame IP checksum, streamed payload, CRC-32 FCS and inter-frame gap.
module udp_mii_frame_tx #(
  parameter int          PAYLOAD_BYTES = 18,
  parameter logic [47:0] DST_MAC       = 48'h8086F23E6AD9,
  parameter logic [47:0] SRC_MAC       = 48'h001234567890,
  parameter logic [31:0] SRC_IP        = 32'hC0A8002C,
  parameter logic [31:0] DST_IP        = 32'hC0A89D01,
  parameter logic [15:0] SRC_PORT      = 16'h0400,
  parameter logic [15:0] DST_PORT      = 16'h0400,
  parameter logic [15:0] IP_ID_INIT    = 16'hB3FE,
  parameter int          IFG_NIBBLES   = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] pay_data,
  input  logic       pay_valid,
  output logic       pay_ready,
  output logic [3:0] txd,
  output logic       tx_en,
  output logic       busy,
  output logic       done,
  output logic       underrun,
  output logic       phy_reset_n
);

  typedef enum logic [2:0] {IDLE, PREAMBLE, HEADER, PAYLOAD, FCS, IFG} state_t;

  localparam logic [15:0] TOTAL_LEN  = 16'(28 + PAYLOAD_BYTES);
  localparam logic [15:0] UDP_LEN    = 16'(8 + PAYLOAD_BYTES);
  localparam logic [11:0] HDR_LAST   = 12'd83;
  localparam logic [11:0] PAY_LAST   = 12'(2 * PAYLOAD_BYTES - 1);
  localparam logic [11:0] IFG_LAST   = 12'(IFG_NIBBLES - 1);
  localparam logic [11:0] DONE_AT    = 12'(IFG_NIBBLES - 2);
  // Every IP header word except ip_id is fixed at elaboration.
  localparam logic [31:0] CSUM_CONST = 32'h4500 + 32'(TOTAL_LEN) + 32'h8011
                                     + 32'(SRC_IP[31:16]) + 32'(SRC_IP[15:0])
                                     + 32'(DST_IP[31:16]) + 32'(DST_IP[15:0]);

  state_t         state;
  logic [11:0]    cnt;
  logic [3:0]     txd_q;
  logic [15:0]    ip_id;
  logic [15:0]    ip_csum;
  logic [31:0]    crc;
  logic [31:0]    crc_next;
  logic [31:0]    fcs_val;
  logic [27:0]    fcs_sr;
  logic [335:0]   hdr_vec;
  logic [335:0]   hdr_sr;
  logic [7:0]     pay_in;

  function automatic logic [31:0] crc_nib(input logic [31:0] c, input logic [3:0] n);
    logic [31:0] r;
    // NOTE: blocking assignments are correct here: r is a local temporary inside a pure function.
    r = c ^ {28'h0, n};
    for (int i = 0; i < 4; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  function automatic logic [15:0] ip_checksum(input logic [15:0] id);
    logic [31:0] s;
    s = CSUM_CONST + {16'h0, id};
    s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
    s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
    return ~s[15:0];
  endfunction

  assign hdr_vec = {DST_MAC, SRC_MAC, 16'h0800,
                    16'h4500, TOTAL_LEN, ip_id, 16'h0000, 16'h8011, ip_csum, SRC_IP, DST_IP,
                    SRC_PORT, DST_PORT, UDP_LEN, 16'h0000};

  assign pay_in      = pay_valid ? pay_data : 8'h00;
  // NOTE: the payload low nibble passes straight from pay_data to txd in the cycle it is accepted;
  // every other nibble comes from txd_q.
  assign txd         = pay_ready ? pay_in[3:0] : txd_q;
  assign crc_next    = crc_nib(crc, txd);
  assign fcs_val     = underrun ? crc_next : ~crc_next;
  assign phy_reset_n = ~reset;

  // NOTE: hdr_sr, fcs_sr and ip_csum are datapath registers loaded before use, so reset leaves them alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      txd_q     <= 4'h0;
      tx_en     <= 1'b0;
      pay_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      underrun  <= 1'b0;
      ip_id     <= IP_ID_INIT;
      crc       <= 32'hFFFFFFFF;
    end else begin
      cnt  <= cnt + 12'd1;
      done <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (start) begin
            state    <= PREAMBLE;
            txd_q    <= 4'h5;
            tx_en    <= 1'b1;
            busy     <= 1'b1;
            underrun <= 1'b0;
            crc      <= 32'hFFFFFFFF;
            ip_csum  <= ip_checksum(ip_id);
          end
        end
        PREAMBLE: begin
          if (cnt == 12'd14) txd_q <= 4'hD;
          else if (cnt == 12'd15) begin
            state  <= HEADER;
            cnt    <= '0;
            hdr_sr <= hdr_vec;
            txd_q  <= hdr_vec[331:328];
          end
        end
        HEADER: begin
          crc <= crc_next;
          if (!cnt[0]) txd_q <= hdr_sr[335:332];
          else if (cnt == HDR_LAST) begin
            state     <= PAYLOAD;
            cnt       <= '0;
            pay_ready <= 1'b1;
          end else begin
            hdr_sr <= {hdr_sr[327:0], 8'h00};
            txd_q  <= hdr_sr[323:320];
          end
        end
        PAYLOAD: begin
          crc <= crc_next;
          if (!cnt[0]) begin
            pay_ready <= 1'b0;
            txd_q     <= pay_in[7:4];
            if (!pay_valid) underrun <= 1'b1;
          end else if (cnt == PAY_LAST) begin
            state  <= FCS;
            cnt    <= '0;
            fcs_sr <= fcs_val[31:4];
            txd_q  <= fcs_val[3:0];
          end else pay_ready <= 1'b1;
        end
        FCS: begin
          if (cnt == 12'd7) begin
            state <= IFG;
            cnt   <= '0;
            tx_en <= 1'b0;
            txd_q <= 4'h0;
          end else begin
            txd_q  <= fcs_sr[3:0];
            fcs_sr <= {4'h0, fcs_sr[27:4]};
          end
        end
        IFG: begin
          if (cnt == DONE_AT) done <= 1'b1;
          if (cnt == IFG_LAST) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            ip_id <= ip_id + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/udp_mii_frame_tx.md
Name: udp_mii_frame_tx

Overview:
Parametrised 10BASE-T/MII transmitter that builds a complete Ethernet/IPv4/UDP frame. The frame is emitted one nibble per TX clock. Payload comes from a byte-stream handshake, not a fixed table. The block computes the IP header checksum per frame (incrementing IP ID) and the Ethernet FCS (CRC-32) on the fly, then enforces the inter-frame gap. It sits between the result/payload producer and the PHY MII TX pins.

Parameters:
PAYLOAD_BYTES, 18, UDP payload length per frame; legal range 18..1472, so no padding is ever needed.
DST_MAC, 48'h8086F23E6AD9, destination MAC.
SRC_MAC, 48'h001234567890, source MAC.
SRC_IP, 32'hC0A8002C, source IP (192.168.0.44).
DST_IP, 32'hC0A89D01, destination IP (192.168.157.1).
SRC_PORT, 16'h0400, UDP source port.
DST_PORT, 16'h0400, UDP destination port.
IP_ID_INIT, 16'hB3FE, IP identification value after reset.
IFG_NIBBLES, 24, idle nibbles after FCS (96 bit times).

Ports:
clk  in  1  MII TX clock; one nibble per cycle.
reset  in  1  synchronous, active-high.
start  in  1  frame request; sampled only in IDLE.
pay_data  in  8  payload byte.
pay_valid  in  1  pay_data valid.
pay_ready  out  1  block consumes pay_data this cycle.
txd  out  4  MII TXD[3:0].
tx_en  out  1  MII TX_EN.
busy  out  1  high in any state other than IDLE.
done  out  1  one-cycle pulse on the last IFG cycle.
underrun  out  1  sticky per frame; set if payload was starved.
phy_reset_n  out  1  combinational ~reset.

Behaviour:
- Reset (synchronous): state=IDLE; txd=0, tx_en=0, pay_ready=0, busy=0, done=0, underrun=0; ip_id=IP_ID_INIT; CRC=FFFFFFFF. Reset mid-frame aborts at that edge, with no FCS and no IFG.
- Clock/reset: one clock, clk; reset is synchronous and active-high.
- Nibble order: low nibble first, then high nibble, per IEEE 802.3 MII.
- States: IDLE -> PREAMBLE -> HEADER -> PAYLOAD -> FCS -> IFG -> IDLE.
- IDLE -> PREAMBLE: start=1 in IDLE. The first preamble nibble (0x5) drives txd with tx_en=1 on the next cycle (latency 1). start while busy is ignored, not queued.
- PREAMBLE: 7 bytes of 0x55, then SFD 0xD5 (15 nibbles of 0x5, then 0xD).
- HEADER: 42 bytes, in order:
  - DST_MAC, SRC_MAC, 0x0800.
  - IP header: 45 00, total length (28+PAYLOAD_BYTES), ip_id, 00 00, TTL 80, proto 11, checksum, SRC_IP, DST_IP.
  - UDP header: SRC_PORT, DST_PORT, length (8+PAYLOAD_BYTES), checksum 0x0000.
  - All multi-byte fields are sent MSB byte first.
- IP checksum: computed during PREAMBLE (16 cycles available). It is the 16-bit ones'-complement sum of the ten header words with the checksum field taken as 0. Carries are folded twice, then the result is inverted. Only ip_id varies at runtime; the remaining constant partial sum may be elaborated.
- PAYLOAD: pay_ready=1 on the low-nibble cycle of each payload byte.
  - pay_valid=1: the byte is captured and its low nibble is driven in that same cycle (combinational path pay_data->txd allowed), or via a one-byte prefetch register. Either way, the txd sequence must be identical.
  - pay_valid=0: 0x00 is substituted, underrun is set, and the frame continues.
- CRC-32 covers DST_MAC through the last payload byte. Parameters: reflected polynomial 0xEDB88320, init FFFFFFFF, updated per nibble, final value inverted.
- FCS: 4 bytes, LSB byte first, low nibble first. If underrun=1, the FCS is additionally bit-inverted so the receiver discards the frame.
- IFG: tx_en=0, txd=0 for IFG_NIBBLES cycles. done pulses on the last IFG cycle.
- On leaving IFG: ip_id increments, wrapping FFFF->0000; underrun clears on the next start.
- Frame length: tx_en stays high for exactly 2*(8+42+PAYLOAD_BYTES+4) consecutive cycles. txd=0 whenever tx_en=0.

Test Plan:
- Reset held for 3 cycles with start=1 -> tx_en=0, txd=0, busy=0, phy_reset_n=0. After reset release, no frame starts until start is sampled in IDLE.
- P=18, payload 00..11 always valid, start once:
  - tx_en high for 144 cycles.
  - First nibbles: 5 ×15, then D.
  - Checksum bytes 68 42.
  - FCS matches the bench CRC-32 model.
  - busy falls 24 cycles after tx_en falls; done pulses once.
- Two back-to-back frames -> ip_id B3FE then B3FF; checksum 6842 then 6841.
- pay_valid=0 on payload byte 5 -> 0x00 sent; underrun=1; FCS equals the bit-inverted model value; the next frame sends correctly and underrun clears.
- start pulsed during PAYLOAD and during IFG -> ignored; exactly one frame transmitted.
- reset asserted at payload byte 10 -> tx_en=0 at that edge; ip_id reset to B3FE; the next start produces a correct full frame.
